// File: rtl/alu_unit.sv
// Integer ALU with an in-order result buffer feeding the CDB.
// Optional feature: define ALU_UNIT_SLT_EN to enable the slt/sltu comparator.
module alu_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_arith,
  input  logic [2:0]                   in_funct3,
  input  logic                         in_funct7,
  input  logic [WIDTH-1:0]             in_src1,
  input  logic [WIDTH-1:0]             in_src2,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         cdb_req,
  input  logic                         cdb_gnt,
  output logic [WIDTH-1:0]             cdb_data,
  output logic [TAG_W-1:0]             cdb_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] result;
  logic [SH_W-1:0]  shamt;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign shamt = in_src2[SH_W-1:0];

  always_comb begin
    result = '0;
    if (!in_arith) begin
      result = in_src1 + in_src2;
    end else begin
      unique case (in_funct3)
        3'b000: result = in_funct7 ? (in_src1 - in_src2) : (in_src1 + in_src2);
        3'b001: result = in_src1 << shamt;
`ifdef ALU_UNIT_SLT_EN
        3'b010: result = {{(WIDTH-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
        3'b011: result = {{(WIDTH-1){1'b0}}, (in_src1 < in_src2)};
`else
        3'b010: result = '0;
        3'b011: result = '0;
`endif
        3'b100: result = in_src1 ^ in_src2;
        3'b101: result = in_funct7 ? WIDTH'($signed(in_src1) >>> shamt) : (in_src1 >> shamt);
        3'b110: result = in_src1 | in_src2;
        3'b111: result = in_src1 & in_src2;
        default: result = '0;
      endcase
    end
  end

  assign in_ready  = (count_q < DEPTH_C);
  assign cdb_req   = (count_q != '0);
  assign cdb_data  = data_q[rd_ptr_q];
  assign cdb_tag   = tag_q[rd_ptr_q];
  assign occupancy = count_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = cdb_req && cdb_gnt && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // Entries are cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        data_q[wr_ptr_q] <= result;
        tag_q[wr_ptr_q]  <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Randomized self-checking bench for alu_unit against a queue-based reference model.
module tb_alu_unit;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_arith = 1'b0;
  logic [2:0]       in_funct3 = '0;
  logic             in_funct7 = 1'b0;
  logic [WIDTH-1:0] in_src1 = '0;
  logic [WIDTH-1:0] in_src2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             cdb_req;
  logic             cdb_gnt = 1'b0;
  logic [WIDTH-1:0] cdb_data;
  logic [TAG_W-1:0] cdb_tag;
  logic [OCC_W-1:0] occupancy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } entry_t;
  entry_t sb [$];

  alu_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_arith(in_arith), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .cdb_data(cdb_data), .cdb_tag(cdb_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the RV32I rules with plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic arith, input logic [2:0] f3,
                                          input logic f7, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if (!arith) return a + b;
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << sh;
`ifdef ALU_UNIT_SLT_EN
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
`else
      3'd2: return 32'd0;
      3'd3: return 32'd0;
`endif
      3'd4: return a ^ b;
      3'd5: begin
        if (f7 && a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input logic v, input logic ar, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                       input logic g, input logic fl);
    in_valid = v; in_arith = ar; in_funct3 = f3; in_funct7 = f7;
    in_src1 = a; in_src2 = b; in_tag = t; cdb_gnt = g; flush = fl;
  endtask

  // One clock: update the model from pre-edge inputs, then compare every output.
  task automatic step();
    bit acc, pp;
    entry_t e;
    acc = in_valid && (sb.size() < DEPTH) && !flush;
    pp  = (sb.size() != 0) && cdb_gnt && !flush;
    e.tag  = in_tag;
    e.data = ref_alu(in_arith, in_funct3, in_funct7, in_src1, in_src2);
    @(posedge clk);
    if (rst || flush) sb.delete();
    else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(e);
    end
    #1;
    check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    check("cdb_req", 64'(cdb_req), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("cdb_data", 64'(cdb_data), 64'(sb[0].data));
      check("cdb_tag", 64'(cdb_tag), 64'(sb[0].tag));
    end
  endtask

  task automatic run_one(input string name, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] t, input logic [31:0] exp);
    drive(1'b1, 1'b1, f3, f7, a, b, t, 1'b0, 1'b0);
    step();
    check(name, 64'(cdb_data), 64'(exp));
    check({name, "_tag"}, 64'(cdb_tag), 64'(t));
    drive(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    cdb_gnt = 1'b0;
  endtask

  initial begin
    logic [31:0] slt_exp;
`ifdef ALU_UNIT_SLT_EN
    slt_exp = 32'd1;
`else
    slt_exp = 32'd0;
`endif
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_req", 64'(cdb_req), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(cdb_data), 64'd0);
    check("rst_tag", 64'(cdb_tag), 64'd0);

    run_one("sub", 3'd0, 1'b1, 32'd5, 32'd7, 5'd3, 32'hFFFF_FFFE);
    run_one("sra", 3'd5, 1'b1, 32'h8000_0000, 32'h21, 5'd4, 32'hC000_0000);
    run_one("srl", 3'd5, 1'b0, 32'h8000_0000, 32'h21, 5'd5, 32'h4000_0000);
    run_one("slt", 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd6, slt_exp);
    run_one("sltu", 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd7, 32'd0);
    // funct3/funct7 ignored for non-arith ops
    drive(1'b1, 1'b0, 3'd4, 1'b1, 32'd9, 32'd10, 5'd8, 1'b0, 1'b0);
    step();
    check("addr_add", 64'(cdb_data), 64'd19);
    drive(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();

    // Fill to capacity with gnt low, hold the extra op, then release one slot.
    for (int i = 0; i <= DEPTH; i++) begin
      drive(1'b1, 1'b1, 3'd6, 1'b0, $urandom, $urandom, 5'(10 + i), 1'b0, 1'b0);
      step();
    end
    check("full_ready", 64'(in_ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'(DEPTH));
    check("full_head", 64'(cdb_tag), 64'd10);
    cdb_gnt = 1'b1;
    step();
    cdb_gnt = 1'b0;
    step();
    check("held_occ", 64'(occupancy), 64'(DEPTH));
    check("held_head", 64'(cdb_tag), 64'd11);

    // Flush with simultaneous push and gnt on a full buffer.
    drive(1'b1, 1'b1, 3'd0, 1'b0, 32'd1, 32'd1, 5'd31, 1'b1, 1'b1);
    step();
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_req", 64'(cdb_req), 64'd0);
    drive(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    step();
    check("flush_gone", 64'(cdb_req), 64'd0);

    // Mid-operation reset drops buffered results.
    drive(1'b1, 1'b1, 3'd4, 1'b0, 32'hA5, 32'h5A, 5'd20, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_occ", 64'(occupancy), 64'd0);
    check("midrst_data", 64'(cdb_data), 64'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000 | 32'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), 1'($urandom),
            a, b, 5'($urandom), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 40) == 0));
      rst = ($urandom_range(0, 150) == 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int n = 0; n < DEPTH + 1; n++) step();
    check("drained", 64'(occupancy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
